ahb_slave_if_param: RTL and testbench

- Parametrised AHB-side slave interface for the AHB-to-APB bridge.
- Decodes a configurable number of APB slave regions and pipelines address, data and write-direction for the downstream APB FSM.
- Adds what the fixed 3-slave interface lacks: protocol-correct two-cycle ERROR responses for unmapped and misaligned transfers, plus Hreadyout stall generation.
- Sits between the AHB master/interconnect and the bridge APB controller.

---
 rtl/ahb_slave_if_param.sv | 219 +++++++++++++++++++++
 tb/tb_ahb_slave_if_param.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_slave_if_param.sv
// ---------------------------------------------------------------------------
// ahb_slave_if_param
//
// AHB-side slave interface of the AHB-to-APB bridge. It decodes the address
// into one of NUM_SLAVES APB regions and pipelines the address, write data
// and write direction for the downstream APB controller. Unmapped and
// misaligned transfers get a two-cycle AHB ERROR response (HREADYOUT low,
// then high, with HRESP = ERROR in both cycles).
//
// Address map: Haddr[ADDR_WIDTH-1 : REGION_SHIFT+IDX_W] must equal BASE_TAG.
// Haddr[REGION_SHIFT +: IDX_W] selects the region. Indices at or above
// NUM_SLAVES are unmapped.
//
// Ports
//   Hclk       in   bridge clock; all state changes on the rising edge
//   Hreset     in   synchronous, active-high reset
//   Hwrite     in   AHB write direction
//   Hreadyin   in   AHB HREADY; an address phase is accepted only when high
//   Htrans     in   [1:0] IDLE/BUSY/NONSEQ/SEQ
//   Hsize      in   [2:0] transfer size, log2 bytes
//   Haddr      in   [ADDR_WIDTH-1:0] AHB address
//   Hwdata     in   [DATA_WIDTH-1:0] AHB write data
//   Prdata     in   [DATA_WIDTH-1:0] read data from the APB side
//   valid      out  accepted, mapped, aligned transfer in this address phase
//   tempselx   out  [NUM_SLAVES-1:0] one-hot region select (ignores Htrans)
//   Haddr1/2   out  address pipeline stages 1 and 2
//   Hwdata1/2  out  write-data pipeline stages 1 and 2
//   Hwritereg  out  registered Hwrite
//   Hrdata     out  combinational copy of Prdata
//   Hresp      out  [1:0] 00 OKAY, 01 ERROR
//   Hreadyout  out  slave ready
// ---------------------------------------------------------------------------
module ahb_slave_if_param #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_SLAVES   = 3,
    parameter int REGION_SHIFT = 26,
    parameter int IDX_W        = 4,
    parameter int BASE_TAG     = 2
) (
    input  logic                  Hclk,
    input  logic                  Hreset,
    input  logic                  Hwrite,
    input  logic                  Hreadyin,
    input  logic [1:0]            Htrans,
    input  logic [2:0]            Hsize,
    input  logic [ADDR_WIDTH-1:0] Haddr,
    input  logic [DATA_WIDTH-1:0] Hwdata,
    input  logic [DATA_WIDTH-1:0] Prdata,
    output logic                  valid,
    output logic [NUM_SLAVES-1:0] tempselx,
    output logic [ADDR_WIDTH-1:0] Haddr1,
    output logic [ADDR_WIDTH-1:0] Haddr2,
    output logic [DATA_WIDTH-1:0] Hwdata1,
    output logic [DATA_WIDTH-1:0] Hwdata2,
    output logic                  Hwritereg,
    output logic [DATA_WIDTH-1:0] Hrdata,
    output logic [1:0]            Hresp,
    output logic                  Hreadyout
);

    // Width of the tag field above the region index.
    localparam int TAG_W    = ADDR_WIDTH - REGION_SHIFT - IDX_W;
    // Largest legal Hsize: 2 for a 32-bit bus, 3 for a 64-bit bus.
    localparam int MAX_SIZE = (DATA_WIDTH == 64) ? 3 : 2;

    localparam logic [TAG_W-1:0] BASE_TAG_V   = TAG_W'(BASE_TAG);
    // One extra bit so NUM_SLAVES == 2**IDX_W still compares correctly.
    localparam logic [IDX_W:0]   NUM_SLAVES_V = (IDX_W + 1)'(NUM_SLAVES);
    localparam logic [2:0]       MAX_SIZE_V   = 3'(MAX_SIZE);

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    typedef enum logic [1:0] {
        ST_OK   = 2'b00,
        ST_ERR1 = 2'b01,
        ST_ERR2 = 2'b10
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [ADDR_WIDTH-1:0] haddr1_q, haddr1_d;
    logic [ADDR_WIDTH-1:0] haddr2_q, haddr2_d;
    logic [DATA_WIDTH-1:0] hwdata1_q, hwdata1_d;
    logic [DATA_WIDTH-1:0] hwdata2_q, hwdata2_d;
    logic                  hwrite_q, hwrite_d;

    // -----------------------------------------------------------------------
    // Address decode
    // -----------------------------------------------------------------------
    logic [TAG_W-1:0]    tag;
    logic [IDX_W-1:0]    idx;
    logic                hit;
    logic                size_ok;
    logic [MAX_SIZE-1:0] low_bit_set;
    logic                aligned;
    logic                in_ok;
    logic                active;

    assign tag = Haddr[ADDR_WIDTH-1 -: TAG_W];
    assign idx = Haddr[REGION_SHIFT +: IDX_W];
    assign hit = (tag == BASE_TAG_V) && ({1'b0, idx} < NUM_SLAVES_V);

    // A transfer of 2**Hsize bytes needs its Hsize low address bits clear.
    // Only bits below MAX_SIZE matter: larger sizes are rejected by size_ok.
    assign size_ok = (Hsize <= MAX_SIZE_V);

    genvar gi;
    generate
        for (gi = 0; gi < MAX_SIZE; gi++) begin : g_align
            assign low_bit_set[gi] = Haddr[gi] && (Hsize > 3'(gi));
        end
    endgenerate

    assign aligned = size_ok && (low_bit_set == '0);

    assign in_ok  = (state_q == ST_OK);
    assign active = Hreadyin && Htrans[1] && in_ok;
    assign valid  = active && hit && aligned;

    // Region select follows the address alone so the APB side can look at it
    // before it knows whether the transfer is real.
    generate
        for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_sel
            assign tempselx[gi] = hit && (idx == IDX_W'(gi));
        end
    endgenerate

    // Htrans[0] only distinguishes NONSEQ from SEQ, which this block treats
    // identically.
    logic unused_htrans0;
    assign unused_htrans0 = Htrans[0];

    assign Hrdata = Prdata;

    // -----------------------------------------------------------------------
    // Pipeline: advances only when the bus is ready and no error response is
    // in progress, otherwise every stage holds.
    // -----------------------------------------------------------------------
    always_comb begin
        haddr1_d  = haddr1_q;
        haddr2_d  = haddr2_q;
        hwdata1_d = hwdata1_q;
        hwdata2_d = hwdata2_q;
        hwrite_d  = hwrite_q;
        if (Hreadyin && in_ok) begin
            haddr1_d  = Haddr;
            haddr2_d  = haddr1_q;
            hwdata1_d = Hwdata;
            hwdata2_d = hwdata1_q;
            hwrite_d  = Hwrite;
        end
    end

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            haddr1_q  <= '0;
            haddr2_q  <= '0;
            hwdata1_q <= '0;
            hwdata2_q <= '0;
            hwrite_q  <= 1'b0;
        end else begin
            haddr1_q  <= haddr1_d;
            haddr2_q  <= haddr2_d;
            hwdata1_q <= hwdata1_d;
            hwdata2_q <= hwdata2_d;
            hwrite_q  <= hwrite_d;
        end
    end

    assign Haddr1    = haddr1_q;
    assign Haddr2    = haddr2_q;
    assign Hwdata1   = hwdata1_q;
    assign Hwdata2   = hwdata2_q;
    assign Hwritereg = hwrite_q;

    // -----------------------------------------------------------------------
    // Error-response FSM. An ERROR is two cycles: ERR1 stalls with
    // Hreadyout low so the master sees the error before the next address
    // phase completes; ERR2 finishes it with Hreadyout high. Whatever the
    // master presents during ERR2 is dropped, since it must cancel to IDLE.
    // -----------------------------------------------------------------------
    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            state_q <= ST_OK;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        Hreadyout = 1'b1;
        Hresp     = RESP_OKAY;
        case (state_q)
            ST_OK: begin
                // Unmapped and misaligned together still give one sequence.
                if (active && !(hit && aligned)) begin
                    state_d = ST_ERR1;
                end
            end
            ST_ERR1: begin
                Hreadyout = 1'b0;
                Hresp     = RESP_ERROR;
                state_d   = ST_ERR2;
            end
            ST_ERR2: begin
                Hresp   = RESP_ERROR;
                state_d = ST_OK;
            end
            default: begin
                state_d = ST_OK;
            end
        endcase
    end

endmodule

// File: tb/tb_ahb_slave_if_param.sv
// ---------------------------------------------------------------------------
// Directed testbench for ahb_slave_if_param. A 3-region instance carries the
// main scenarios; an 8-region instance shares the same stimulus and is
// checked for the top region select. Inputs change and combinational outputs
// are checked on the falling edge; registered outputs are checked on the
// falling edge following the rising edge that updated them.
// ---------------------------------------------------------------------------
module tb_ahb_slave_if_param;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          Hclk = 1'b0;
    logic          Hreset;
    logic          Hwrite;
    logic          Hreadyin;
    logic [1:0]    Htrans;
    logic [2:0]    Hsize;
    logic [AW-1:0] Haddr;
    logic [DW-1:0] Hwdata;
    logic [DW-1:0] Prdata;

    logic          valid;
    logic [2:0]    tempselx;
    logic [AW-1:0] Haddr1, Haddr2;
    logic [DW-1:0] Hwdata1, Hwdata2;
    logic          Hwritereg;
    logic [DW-1:0] Hrdata;
    logic [1:0]    Hresp;
    logic          Hreadyout;

    logic          valid8;
    logic [7:0]    tempselx8;
    logic [AW-1:0] Haddr1_8, Haddr2_8;
    logic [DW-1:0] Hwdata1_8, Hwdata2_8;
    logic          Hwritereg8;
    logic [DW-1:0] Hrdata8;
    logic [1:0]    Hresp8;
    logic          Hreadyout8;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11;

    always #5 Hclk = ~Hclk;

    ahb_slave_if_param #(.NUM_SLAVES(3)) dut (
        .Hclk(Hclk), .Hreset(Hreset), .Hwrite(Hwrite), .Hreadyin(Hreadyin),
        .Htrans(Htrans), .Hsize(Hsize), .Haddr(Haddr), .Hwdata(Hwdata),
        .Prdata(Prdata), .valid(valid), .tempselx(tempselx),
        .Haddr1(Haddr1), .Haddr2(Haddr2), .Hwdata1(Hwdata1), .Hwdata2(Hwdata2),
        .Hwritereg(Hwritereg), .Hrdata(Hrdata), .Hresp(Hresp),
        .Hreadyout(Hreadyout)
    );

    ahb_slave_if_param #(.NUM_SLAVES(8)) dut8 (
        .Hclk(Hclk), .Hreset(Hreset), .Hwrite(Hwrite), .Hreadyin(Hreadyin),
        .Htrans(Htrans), .Hsize(Hsize), .Haddr(Haddr), .Hwdata(Hwdata),
        .Prdata(Prdata), .valid(valid8), .tempselx(tempselx8),
        .Haddr1(Haddr1_8), .Haddr2(Haddr2_8), .Hwdata1(Hwdata1_8),
        .Hwdata2(Hwdata2_8), .Hwritereg(Hwritereg8), .Hrdata(Hrdata8),
        .Hresp(Hresp8), .Hreadyout(Hreadyout8)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one address phase; the #1 lets decode settle before checks.
    task automatic drive(input logic [1:0] trans, input logic wr,
                         input logic [2:0] size, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic rdy);
        Htrans   = trans;
        Hwrite   = wr;
        Hsize    = size;
        Haddr    = addr;
        Hwdata   = wdata;
        Hreadyin = rdy;
        #1;
        $display("[%0t] trans=%0d wr=%0b size=%0d addr=0x%08h wdata=0x%08h rdy=%0b",
                 $time, trans, wr, size, addr, wdata, rdy);
    endtask

    task automatic tick();
        @(posedge Hclk);
        @(negedge Hclk);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Hreset = 1'b1;
        Prdata = '0;
        @(negedge Hclk);
        drive(IDLE, 1'b0, 3'd2, 32'h0, 32'h0, 1'b1);
        tick();
        tick();

        // Reset state
        check("rst_haddr1",    64'(Haddr1),    64'h0);
        check("rst_haddr2",    64'(Haddr2),    64'h0);
        check("rst_hwdata2",   64'(Hwdata2),   64'h0);
        check("rst_hwritereg", 64'(Hwritereg), 64'h0);
        check("rst_hresp",     64'(Hresp),     64'h0);
        check("rst_hreadyout", 64'(Hreadyout), 64'h1);
        Hreset = 1'b0;

        // Hrdata pass-through
        Prdata = 32'hCAFE_F00D;
        #1;
        check("hrdata_pass", 64'(Hrdata), 64'hCAFE_F00D);

        // Scenario 1: single NONSEQ write to region 0
        drive(NONSEQ, 1'b1, 3'd2, 32'h8000_0000, 32'h1234_5678, 1'b1);
        check("s1_valid",    64'(valid),    64'h1);
        check("s1_tempselx", 64'(tempselx), 64'h1);
        tick();
        check("s1_haddr1",    64'(Haddr1),    64'h8000_0000);
        check("s1_hwdata1",   64'(Hwdata1),   64'h1234_5678);
        check("s1_hwritereg", 64'(Hwritereg), 64'h1);
        check("s1_hresp",     64'(Hresp),     64'h0);
        drive(IDLE, 1'b0, 3'd2, 32'h0, 32'h0, 1'b1);
        tick();
        check("s1_haddr2",  64'(Haddr2),  64'h8000_0000);
        check("s1_hwdata2", 64'(Hwdata2), 64'h1234_5678);
        check("s1_haddr1b", 64'(Haddr1),  64'h0);

        // Scenario 2: back-to-back reads to regions 1 and 2
        drive(NONSEQ, 1'b0, 3'd2, 32'h8400_0000, 32'h0, 1'b1);
        check("s2_valid_a",  64'(valid),     64'h1);
        check("s2_sel_a",    64'(tempselx),  64'h2);
        tick();
        check("s2_ready_a",  64'(Hreadyout), 64'h1);
        check("s2_haddr1_a", 64'(Haddr1),    64'h8400_0000);
        check("s2_hwrite_a", 64'(Hwritereg), 64'h0);
        drive(SEQ, 1'b0, 3'd2, 32'h8800_0000, 32'h0, 1'b1);
        check("s2_valid_b",  64'(valid),     64'h1);
        check("s2_sel_b",    64'(tempselx),  64'h4);
        tick();
        check("s2_ready_b",  64'(Hreadyout), 64'h1);
        check("s2_haddr1_b", 64'(Haddr1),    64'h8800_0000);
        check("s2_haddr2_b", 64'(Haddr2),    64'h8400_0000);

        // Scenario 3: unmapped region 3 -> two-cycle ERROR
        drive(NONSEQ, 1'b1, 3'd2, 32'h8C00_0000, 32'h5555_0000, 1'b1);
        check("s3_valid",    64'(valid),     64'h0);
        check("s3_sel",      64'(tempselx),  64'h0);
        check("s3_ready0",   64'(Hreadyout), 64'h1);
        tick();
        check("s3_err1_rdy",  64'(Hreadyout), 64'h0);
        check("s3_err1_resp", 64'(Hresp),     64'h1);
        // Mapped transfer offered during ERR1 must be ignored.
        drive(NONSEQ, 1'b0, 3'd2, 32'h8000_0000, 32'h0, 1'b1);
        check("s3_err1_valid", 64'(valid), 64'h0);
        tick();
        check("s3_err2_rdy",   64'(Hreadyout), 64'h1);
        check("s3_err2_resp",  64'(Hresp),     64'h1);
        check("s3_err2_haddr1", 64'(Haddr1),   64'h8C00_0000);
        drive(NONSEQ, 1'b0, 3'd2, 32'h8400_0000, 32'h0, 1'b1);
        check("s3_err2_valid", 64'(valid), 64'h0);
        tick();
        check("s3_ok_resp",   64'(Hresp),     64'h0);
        check("s3_ok_rdy",    64'(Hreadyout), 64'h1);
        check("s3_ok_haddr1", 64'(Haddr1),    64'h8C00_0000);
        check("s3_ok_hwrite", 64'(Hwritereg), 64'h1);

        // Scenario 4: misaligned word, then legal halfword at same address
        drive(NONSEQ, 1'b0, 3'd2, 32'h8000_0002, 32'h0, 1'b1);
        check("s4_mis_valid", 64'(valid), 64'h0);
        tick();
        check("s4_err1_rdy",  64'(Hreadyout), 64'h0);
        check("s4_err1_resp", 64'(Hresp),     64'h1);
        drive(IDLE, 1'b0, 3'd2, 32'h0, 32'h0, 1'b1);
        tick();
        check("s4_err2_rdy",  64'(Hreadyout), 64'h1);
        check("s4_err2_resp", 64'(Hresp),     64'h1);
        tick();
        check("s4_ok_resp", 64'(Hresp), 64'h0);
        drive(NONSEQ, 1'b0, 3'd1, 32'h8000_0002, 32'h0, 1'b1);
        check("s4_half_valid", 64'(valid),    64'h1);
        check("s4_half_sel",   64'(tempselx), 64'h1);
        tick();
        check("s4_half_resp", 64'(Hresp),     64'h0);
        check("s4_half_rdy",  64'(Hreadyout), 64'h1);
        // Doubleword on a 32-bit bus is oversized even when aligned.
        drive(NONSEQ, 1'b0, 3'd3, 32'h8000_0000, 32'h0, 1'b1);
        check("s4_big_valid", 64'(valid), 64'h0);
        tick();
        check("s4_big_rdy", 64'(Hreadyout), 64'h0);
        drive(IDLE, 1'b0, 3'd2, 32'h0, 32'h0, 1'b1);
        tick();
        tick();
        check("s4_big_done", 64'(Hresp), 64'h0);

        // Scenario 5: Hreadyin low holds the pipeline; BUSY/IDLE are OKAY
        drive(NONSEQ, 1'b1, 3'd2, 32'h8000_0010, 32'hAAAA_5555, 1'b1);
        tick();
        check("s5_pre_haddr1", 64'(Haddr1), 64'h8000_0010);
        drive(NONSEQ, 1'b0, 3'd2, 32'h8400_0000, 32'hDEAD_BEEF, 1'b0);
        check("s5_nrdy_valid", 64'(valid), 64'h0);
        tick();
        check("s5_hold_haddr1", 64'(Haddr1),    64'h8000_0010);
        check("s5_hold_hwdata", 64'(Hwdata1),   64'hAAAA_5555);
        check("s5_hold_hwrite", 64'(Hwritereg), 64'h1);
        check("s5_hold_resp",   64'(Hresp),     64'h0);
        drive(BUSY, 1'b0, 3'd2, 32'h8400_0000, 32'h0, 1'b1);
        check("s5_busy_valid", 64'(valid), 64'h0);
        tick();
        check("s5_busy_resp", 64'(Hresp),     64'h0);
        check("s5_busy_rdy",  64'(Hreadyout), 64'h1);
        drive(IDLE, 1'b0, 3'd2, 32'h8400_0000, 32'h0, 1'b1);
        check("s5_idle_valid", 64'(valid),    64'h0);
        check("s5_idle_sel",   64'(tempselx), 64'h2);
        tick();
        check("s5_idle_resp", 64'(Hresp), 64'h0);

        // Scenario 6: reset asserted during ERR1
        drive(NONSEQ, 1'b1, 3'd2, 32'h8C00_0000, 32'h1111_2222, 1'b1);
        tick();
        check("s6_err1_rdy", 64'(Hreadyout), 64'h0);
        Hreset = 1'b1;
        drive(IDLE, 1'b0, 3'd2, 32'h0, 32'h0, 1'b1);
        tick();
        check("s6_rst_rdy",     64'(Hreadyout), 64'h1);
        check("s6_rst_resp",    64'(Hresp),     64'h0);
        check("s6_rst_haddr1",  64'(Haddr1),    64'h0);
        check("s6_rst_haddr2",  64'(Haddr2),    64'h0);
        check("s6_rst_hwdata1", 64'(Hwdata1),   64'h0);
        check("s6_rst_hwdata2", 64'(Hwdata2),   64'h0);
        check("s6_rst_hwrite",  64'(Hwritereg), 64'h0);
        Hreset = 1'b0;

        // Scenario 7: eight regions, top region
        drive(NONSEQ, 1'b1, 3'd2, 32'h9C00_0000, 32'h1234_5678, 1'b1);
        check("s7_valid8", 64'(valid8),    64'h1);
        check("s7_sel8",   64'(tempselx8), 64'h80);
        check("s7_valid3", 64'(valid),     64'h0);
        tick();
        check("s7_haddr1_8", 64'(Haddr1_8), 64'h9C00_0000);
        check("s7_resp8",    64'(Hresp8),   64'h0);
        drive(IDLE, 1'b0, 3'd2, 32'h0, 32'h0, 1'b1);
        tick();
        check("s7_haddr2_8",  64'(Haddr2_8),  64'h9C00_0000);
        check("s7_hwdata2_8", 64'(Hwdata2_8), 64'h1234_5678);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
